lane_unstriper_pipe: RTL and testbench



---
 rtl/lane_unstriper_pipe_if.sv | 30 +++
 rtl/lane_unstriper_pipe.sv | 140 ++++++++++++++
 tb/tb_lane_unstriper_pipe.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_unstriper_pipe_if.sv
// rtl/lane_unstriper_pipe_if.sv - handshake and data bus bundle for the PIPE RX lane unstriper
`timescale 1ns/1ps

interface lane_unstriper_pipe_if #(
  parameter int DATA_W = 512,
  parameter int K_W    = DATA_W / 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] strippedData;
  logic [K_W-1:0]    strippedDataK;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] unstripedData;
  logic [K_W-1:0]    unstripedDataK;
  logic [9:0]        out_nbytes;
  logic              cfg_err;

  // Source of input beats and sink of output beats
  modport master (
    output in_valid, strippedData, strippedDataK, out_ready,
    input  in_ready, out_valid, unstripedData, unstripedDataK, out_nbytes, cfg_err
  );

  // The unstriper itself
  modport slave (
    input  in_valid, strippedData, strippedDataK, out_ready,
    output in_ready, out_valid, unstripedData, unstripedDataK, out_nbytes, cfg_err
  );
endinterface

// File: rtl/lane_unstriper_pipe.sv
// rtl/lane_unstriper_pipe.sv - lane-major to byte-time-major unstriper with 2-entry output FIFO; optional UNSTRIPE_LANE_REVERSAL_EN
`timescale 1ns/1ps

module lane_unstriper_pipe #(
  parameter int MAX_LANES = 16,
  parameter int MAX_BPL   = 4,
  parameter int DATA_W    = MAX_LANES * MAX_BPL * 8,
  parameter int K_W       = DATA_W / 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] PIPEWIDTH,
  input  logic [4:0] LANESNUMBER,
`ifdef UNSTRIPE_LANE_REVERSAL_EN
  input  logic       lane_reverse,
`endif
  lane_unstriper_pipe_if.slave bus
);

  localparam int IW = (K_W > 1) ? $clog2(K_W) : 1;

  logic       pw_ok;
  logic       ln_ok;
  logic       legal;
  logic [2:0] bpl_lg;
  logic [2:0] n_lg;

  logic [DATA_W-1:0] map_data;
  logic [K_W-1:0]    map_k;
  logic [9:0]        map_nbytes;

  logic [DATA_W-1:0] mem_data [2];
  logic [K_W-1:0]    mem_k    [2];
  logic [9:0]        mem_nb   [2];
  logic              mem_err  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  // Decode runtime width and lane count into log2 form and legality
  always_comb begin
    pw_ok  = 1'b1;
    ln_ok  = 1'b1;
    bpl_lg = 3'd0;
    n_lg   = 3'd0;
    case (PIPEWIDTH)
      6'd8:    bpl_lg = 3'd0;
      6'd16:   bpl_lg = 3'd1;
      6'd32:   bpl_lg = 3'd2;
      default: pw_ok  = 1'b0;
    endcase
    case (LANESNUMBER)
      5'd1:    n_lg  = 3'd0;
      5'd2:    n_lg  = 3'd1;
      5'd4:    n_lg  = 3'd2;
      5'd8:    n_lg  = 3'd3;
      5'd16:   n_lg  = 3'd4;
      default: ln_ok = 1'b0;
    endcase
    if ((1 << bpl_lg) > MAX_BPL) pw_ok = 1'b0;
    if ((1 << n_lg) > MAX_LANES) ln_ok = 1'b0;
    legal = pw_ok & ln_ok;
  end

  // Output byte k is byte-time t = k/N of logical lane L = k%N; gather it from lane-major input
  always_comb begin
    int        n;
    int        bpl;
    int        t;
    int        l;
    int        pl;
    logic [IW-1:0] src;
    map_data   = '0;
    map_k      = '0;
    n          = 1 << n_lg;
    bpl        = 1 << bpl_lg;
    t          = 0;
    l          = 0;
    pl         = 0;
    src        = '0;
    map_nbytes = legal ? 10'(n * bpl) : 10'd0;
    for (int k = 0; k < K_W; k++) begin
      t = k >> n_lg;
      l = k & (n - 1);
`ifdef UNSTRIPE_LANE_REVERSAL_EN
      pl = lane_reverse ? (n - 1 - l) : l;
`else
      pl = l;
`endif
      src = IW'((pl << bpl_lg) + t);
      if (legal && (t < bpl)) begin
        map_data[k*8 +: 8] = bus.strippedData[src*8 +: 8];
        map_k[k]           = bus.strippedDataK[src];
      end
    end
  end

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Two-entry FIFO: each entry stores an already-mapped beat so later config changes cannot touch it
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_k[i]    <= '0;
        mem_nb[i]   <= '0;
        mem_err[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= map_data;
        mem_k[wr_ptr]    <= map_k;
        mem_nb[wr_ptr]   <= map_nbytes;
        mem_err[wr_ptr]  <= ~legal;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Flow control from occupancy only; head fields come straight from the head entry
  always_comb begin
    bus.in_ready       = (count != 2'd2);
    bus.out_valid      = (count != 2'd0);
    bus.unstripedData  = mem_data[rd_ptr];
    bus.unstripedDataK = mem_k[rd_ptr];
    bus.out_nbytes     = mem_nb[rd_ptr];
    bus.cfg_err        = mem_err[rd_ptr];
  end

endmodule

// File: tb/tb_lane_unstriper_pipe.sv
// tb/tb_lane_unstriper_pipe.sv - scoreboard bench for lane_unstriper_pipe with a behavioural reference model
`timescale 1ns/1ps

module tb_lane_unstriper_pipe;
  localparam int MAX_LANES = 16;
  localparam int MAX_BPL   = 4;
  localparam int DW        = MAX_LANES * MAX_BPL * 8;
  localparam int KW        = DW / 8;
  localparam int CW        = 600;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [9:0]    nb;
    logic          err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] pw_r;
  logic [4:0] ln_r;
  logic       rev_r;
  int         checks;
  int         errors;
  int         cyc;
  int         rdy_mode;
  exp_t       sb[$];
  logic       hold_v;
  logic [CW-1:0] held;

  lane_unstriper_pipe_if #(.DATA_W(DW)) ifc ();

  lane_unstriper_pipe #(.MAX_LANES(MAX_LANES), .MAX_BPL(MAX_BPL)) dut (
    .clk         (clk),
    .reset       (reset),
    .PIPEWIDTH   (pw_r),
    .LANESNUMBER (ln_r),
`ifdef UNSTRIPE_LANE_REVERSAL_EN
    .lane_reverse(rev_r),
`endif
    .bus         (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: byte t of logical lane L lands at stream position t*N+L
  function automatic exp_t model(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input int pw, input int n, input bit rev);
    exp_t e;
    bit   legal;
    int   bpl;
    int   pl;
    e.d   = '0;
    e.k   = '0;
    e.nb  = '0;
    legal = ((pw == 8) || (pw == 16) || (pw == 32)) && (pw / 8 <= MAX_BPL) &&
            ((n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16)) && (n <= MAX_LANES);
    e.err = !legal;
    if (legal) begin
      bpl  = pw / 8;
      e.nb = 10'(n * bpl);
      for (int t = 0; t < bpl; t++) begin
        for (int l = 0; l < n; l++) begin
          pl = rev ? (n - 1 - l) : l;
          e.d[(t*n + l)*8 +: 8] = d[(pl*bpl + t)*8 +: 8];
          e.k[t*n + l]          = k[pl*bpl + t];
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted; the expected result is queued at acceptance
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input int pw, input int n, input bit rev);
    int waitc;
    ifc.in_valid      = 1'b1;
    ifc.strippedData  = d;
    ifc.strippedDataK = k;
    pw_r              = 6'(pw);
    ln_r              = 5'(n);
    rev_r             = rev;
    waitc             = 0;
    while (!ifc.in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!ifc.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %0d, required 1", ifc.in_ready);
    end else begin
      sb.push_back(model(d, k, int'(pw_r), int'(ln_r), rev));
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drain everything, then leave the sink stalled with an empty FIFO
  task automatic drain_and_stall();
    int waitc;
    rdy_mode = 1;
    waitc    = 0;
    wait_cycles(2);
    while ((ifc.out_valid || sb.size() != 0) && waitc < 100) begin
      wait_cycles(1);
      waitc++;
    end
    if (ifc.out_valid || sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
    end
    rdy_mode = 0;
    wait_cycles(2);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Sink ready: stalled, always ready, or random
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) ifc.out_ready = ($urandom_range(0, 3) != 0);
    else               ifc.out_ready = (rdy_mode == 1);
  end

  // Monitor: compare each output transfer against the scoreboard and check head stability on stalls
  always @(negedge clk) begin
    exp_t e;
    logic [CW-1:0] cur;
    cur = CW'({ifc.unstripedData, ifc.unstripedDataK, ifc.out_nbytes, ifc.cfg_err});
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && ifc.out_valid) chk("head_stable", cur, held);
      if (ifc.out_valid && ifc.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: out transfer with %0d expected beats queued, required >0", sb.size());
        end else begin
          e = sb.pop_front();
          chk("out_data",   CW'(ifc.unstripedData),  CW'(e.d));
          chk("out_k",      CW'(ifc.unstripedDataK), CW'(e.k));
          chk("out_nbytes", CW'(ifc.out_nbytes),     CW'(e.nb));
          chk("cfg_err",    CW'(ifc.cfg_err),        CW'(e.err));
        end
      end
      hold_v = ifc.out_valid && !ifc.out_ready;
      held   = cur;
    end
  end

  initial begin
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    int            c0;
    int            pw;
    int            n;
    bit            rev;
    int            pw_tab[6];
    int            n_tab[8];
    pw_tab = '{8, 16, 32, 8, 24, 0};
    n_tab  = '{1, 2, 4, 8, 16, 3, 0, 31};
    checks            = 0;
    errors            = 0;
    cyc               = 0;
    rdy_mode          = 0;
    hold_v            = 1'b0;
    held              = '0;
    reset             = 1'b1;
    ifc.in_valid      = 1'b0;
    ifc.strippedData  = '0;
    ifc.strippedDataK = '0;
    ifc.out_ready     = 1'b0;
    pw_r              = 6'd8;
    ln_r              = 5'd1;
    rev_r             = 1'b0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);

    chk("rst_in_ready",  CW'(ifc.in_ready),       CW'(1));
    chk("rst_out_valid", CW'(ifc.out_valid),      CW'(0));
    chk("rst_data",      CW'(ifc.unstripedData),  CW'(0));
    chk("rst_k",         CW'(ifc.unstripedDataK), CW'(0));
    chk("rst_nbytes",    CW'(ifc.out_nbytes),     CW'(0));
    chk("rst_cfg_err",   CW'(ifc.cfg_err),        CW'(0));

    // x8, four lanes: identity order
    drain_and_stall();
    d = '0; d[31:0] = 32'h44332211; k = '0;
    send(d, k, 8, 4, 1'b0);
    chk("t1_data",   CW'(ifc.unstripedData[31:0]), CW'(32'h44332211));
    chk("t1_nbytes", CW'(ifc.out_nbytes),          CW'(4));

    // x16, two lanes: bytes interleave across lanes
    drain_and_stall();
    d = '0; d[31:0] = 32'hB1B0A1A0; k = '0; k[3:0] = 4'b0001;
    send(d, k, 16, 2, 1'b0);
    chk("t2_data",   CW'(ifc.unstripedData[31:0]), CW'(32'hB1A1B0A0));
    chk("t2_k",      CW'(ifc.unstripedDataK[3:0]), CW'(4'b0001));
    chk("t2_nbytes", CW'(ifc.out_nbytes),          CW'(4));

    // Illegal width: beat accepted but flagged and zeroed, next legal beat clean
    drain_and_stall();
    d = rand_data(); k = '1;
    send(d, k, 24, 4, 1'b0);
    chk("t5_cfg_err", CW'(ifc.cfg_err),        CW'(1));
    chk("t5_data",    CW'(ifc.unstripedData),  CW'(0));
    chk("t5_k",       CW'(ifc.unstripedDataK), CW'(0));
    chk("t5_nbytes",  CW'(ifc.out_nbytes),     CW'(0));
    send(rand_data(), '1, 8, 4, 1'b0);

`ifdef UNSTRIPE_LANE_REVERSAL_EN
    drain_and_stall();
    d = '0; d[31:0] = 32'h44332211; k = '0;
    send(d, k, 8, 4, 1'b1);
    chk("rev_data", CW'(ifc.unstripedData[31:0]), CW'(32'h11223344));
`endif

    // x32, sixteen lanes, 100 back-to-back beats with no bubbles
    drain_and_stall();
    rdy_mode = 1;
    wait_cycles(2);
    for (int i = 0; i < KW; i++) d[i*8 +: 8] = 8'(i);
    c0 = cyc;
    send(d, '0, 32, 16, 1'b0);
    for (int i = 1; i < 100; i++) send(rand_data(), KW'({$urandom, $urandom}), 32, 16, 1'b0);
    chk("t3_cycles", CW'(cyc - c0), CW'(100));

    // Stalled sink: third beat is held off, then order is preserved on release
    drain_and_stall();
    send(rand_data(), '0, 16, 8, 1'b0);
    send(rand_data(), '1, 8, 16, 1'b0);
    d = rand_data();
    ifc.in_valid     = 1'b1;
    ifc.strippedData = d;
    for (int i = 0; i < 4; i++) begin
      chk("t4_in_ready",  CW'(ifc.in_ready),  CW'(0));
      chk("t4_out_valid", CW'(ifc.out_valid), CW'(1));
      wait_cycles(1);
    end
    rdy_mode = 1;
    send(d, '0, 32, 2, 1'b0);

    // Reset with a full FIFO drops both beats; beats offered during reset are ignored
    drain_and_stall();
    send(rand_data(), '1, 8, 8, 1'b0);
    send(rand_data(), '1, 16, 4, 1'b0);
    reset            = 1'b1;
    ifc.in_valid     = 1'b1;
    ifc.strippedData = rand_data();
    wait_cycles(2);
    reset        = 1'b0;
    ifc.in_valid = 1'b0;
    sb.delete();
    chk("t6_in_ready",  CW'(ifc.in_ready),       CW'(1));
    chk("t6_out_valid", CW'(ifc.out_valid),      CW'(0));
    chk("t6_data",      CW'(ifc.unstripedData),  CW'(0));
    chk("t6_k",         CW'(ifc.unstripedDataK), CW'(0));
    chk("t6_nbytes",    CW'(ifc.out_nbytes),     CW'(0));
    chk("t6_cfg_err",   CW'(ifc.cfg_err),        CW'(0));

    // Random configs, data, idle gaps and sink stalls
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      pw = ($urandom_range(0, 9) == 0) ? pw_tab[$urandom_range(4, 5)] : pw_tab[$urandom_range(0, 3)];
      n  = ($urandom_range(0, 9) == 0) ? n_tab[$urandom_range(5, 7)]  : n_tab[$urandom_range(0, 4)];
`ifdef UNSTRIPE_LANE_REVERSAL_EN
      rev = 1'($urandom_range(0, 1));
`else
      rev = 1'b0;
`endif
      send(rand_data(), KW'({$urandom, $urandom}), pw, n, rev);
      if ($urandom_range(0, 4) == 0) wait_cycles($urandom_range(1, 3));
    end

    drain_and_stall();
    chk("final_out_valid", CW'(ifc.out_valid), CW'(0));
    chk("final_in_ready",  CW'(ifc.in_ready),  CW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
